// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter/sequencer sharing one SRAM controller
// among NUM_REQ requesters. One command is latched in S_IDLE. It is issued as
// a single-cycle read or write pulse once mem_ready is high. The arbiter
// then waits for mem_ack and returns a one-cycle one-hot ack to the winner.
//
// Optional build macro: ARB_TIMEOUT_EN adds an S_WAIT watchdog. After
// TIMEOUT_CYCLES cycles without mem_ack, the transaction completes with err=1.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req/req_we                per-requester request and write select
//   req_addr/req_wdata        packed per-requester address / write data
//   ack, rdata, err           completion pulse, read data, error flag
//   grant_id, busy            latched winner index, not-idle indicator
//   mem_read_req/write_req    one-cycle command pulses to the controller
//   mem_addr/mem_wdata        latched command address / data
//   mem_ready/ack/rdata       controller handshake and read data
module sram_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [DATA_W-1:0]            rdata,
  output logic                         err,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         mem_read_req,
  output logic                         mem_write_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_ready,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int          IDW = $clog2(NUM_REQ);
  localparam int unsigned NR  = NUM_REQ;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win_id;
  logic           win_vld;
  logic           we_lat;

`ifdef ARB_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          err_lat;
  logic          to_hit;
  assign to_hit = (state == S_WAIT) && !mem_ack && (to_cnt == TO_LAST);
`else
  // Watchdog limit is meaningless without the watchdog.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Round-robin search starting just after the last winner.
  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand    = (32'(ptr) + i) % NR;
      cand_id = IDW'(cand);
      if (!win_vld && req[cand_id]) begin
        win_vld = 1'b1;
        win_id  = cand_id;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    case (state)
      S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
      S_ISSUE: begin
        mem_read_req  = !we_lat && mem_ready;
        mem_write_req = we_lat && mem_ready;
        if (mem_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack) state_nxt = S_RESP;
`ifdef ARB_TIMEOUT_EN
        else if (to_hit) state_nxt = S_RESP;
`endif
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= IDW'(NR - 1);
      grant_id  <= '0;
      we_lat    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (win_vld) begin
          grant_id  <= win_id;
          we_lat    <= req_we[win_id];
          mem_addr  <= req_addr[win_id*ADDR_W +: ADDR_W];
          mem_wdata <= req_wdata[win_id*DATA_W +: DATA_W];
        end
        S_WAIT: if (mem_ack && !we_lat) rdata <= mem_rdata;
        S_RESP: ptr <= grant_id;
        default: ;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      err_lat <= 1'b0;
    end else if (state == S_ISSUE) begin
      to_cnt  <= '0;
      err_lat <= 1'b0;
    end else if (state == S_WAIT) begin
      to_cnt <= to_cnt + 1'b1;
      if (to_hit) err_lat <= 1'b1;
    end
  end
  assign err = (state == S_RESP) && err_lat;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    ack = '0;
    if (state == S_RESP) ack[grant_id] = 1'b1;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus pushes expected commands and
// completions into queues, a monitor pops and compares on every DUT pulse.
module tb_sram_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req, req_we, ack;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]     mem_addr;
  logic [1:0]        grant_id;
  logic              err, busy, mem_read_req, mem_write_req, mem_ready, mem_ack;

  sram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .rdata(rdata), .err(err),
    .grant_id(grant_id), .busy(busy), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [7:0] addr; logic [15:0] wdata; } cmd_t;
  typedef struct { logic [3:0] ak; logic [1:0] gid; logic [15:0] rd; logic e; } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  int    total = 0;
  int    bad   = 0;

  logic        mem_ack_en;
  int          mem_delay;
  logic [15:0] mem_rd_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic we, input logic [7:0] a, input logic [15:0] d);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_cmd(input logic we, input logic [7:0] a, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    cmd_q.push_back(c);
  endtask

  task automatic exp_resp(input logic [3:0] ak, input logic [1:0] g, input logic [15:0] rd, input logic e);
    resp_t r;
    r.ak = ak; r.gid = g; r.rd = rd; r.e = e;
    resp_q.push_back(r);
  endtask

  // Waits for an ack pulse; n = negedges counted, including the ack one.
  task automatic wait_ack(input string name, output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ack != '0) return;
    end
    check({name, "_ack_timeout"}, 32'(n), 32'(0));
  endtask

  task automatic wait_cmd(input string name);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (mem_read_req || mem_write_req) return;
    end
    check({name, "_cmd_timeout"}, 32'(1), 32'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Memory controller model: ack mem_delay cycles after a command pulse.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && mem_ack_en && (mem_read_req || mem_write_req)) begin
        repeat (mem_delay) @(posedge clk);
        #1 mem_ack = 1'b1; mem_rdata = mem_rd_val;
        @(posedge clk);
        #1 mem_ack = 1'b0; mem_rdata = '0;
      end
    end
  end

  // Monitor: compares every command pulse and every ack against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_read_req || mem_write_req) begin
          if (cmd_q.size() == 0) check("unexpected_cmd", 32'(1), 32'(0));
          else begin
            cmd_t c;
            c = cmd_q.pop_front();
            check("cmd_kind", {30'b0, mem_write_req, mem_read_req}, c.we ? 32'h2 : 32'h1);
            check("cmd_addr", 32'(mem_addr), 32'(c.addr));
            check("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
          end
        end
        if (ack != '0) begin
          if (resp_q.size() == 0) check("unexpected_ack", 32'(ack), 32'(0));
          else begin
            resp_t r;
            r = resp_q.pop_front();
            check("ack", 32'(ack), 32'(r.ak));
            check("grant_id", 32'(grant_id), 32'(r.gid));
            check("rdata", 32'(rdata), 32'(r.rd));
            check("err", 32'(err), 32'(r.e));
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_ready = 1'b1; mem_ack_en = 1'b1; mem_delay = 2; mem_rd_val = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_err", 32'(err), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_cmd", {30'b0, mem_write_req, mem_read_req}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Write from requester 0.
    set_lane(0, 1'b1, 8'h12, 16'hBEEF);
    exp_cmd(1'b1, 8'h12, 16'hBEEF);
    exp_resp(4'b0001, 2'd0, 16'h0000, 1'b0);
    req = 4'b0001;
    wait_ack("wr", n);
    check("wr_latency", 32'(n), 32'(5));
    @(posedge clk); #1 req = '0;

    // Read from requester 2.
    mem_rd_val = 16'h5A5A;
    set_lane(2, 1'b0, 8'h34, 16'h1111);
    exp_cmd(1'b0, 8'h34, 16'h1111);
    exp_resp(4'b0100, 2'd2, 16'h5A5A, 1'b0);
    req = 4'b0100;
    wait_ack("rd", n);
    check("rd_latency", 32'(n), 32'(5));
    @(posedge clk); #1 req = '0;

    // Round-robin from a fresh pointer: 0,1,2,3,0,1.
    do_reset();
    mem_rd_val = 16'hC0DE;
    for (int i = 0; i < 4; i++) set_lane(i, i[0], 8'(8'h40 + i), 16'(16'h1000 + i));
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % 4;
      exp_cmd(g[0], 8'(8'h40 + g), 16'(16'h1000 + g));
      exp_resp(4'(1 << g), 2'(g), 16'hC0DE, 1'b0);
    end
    req = 4'b1111;
    for (int k = 0; k < 6; k++) wait_ack("rr", n);
    @(posedge clk); #1 req = '0;

    // Backpressure in S_ISSUE.
    set_lane(1, 1'b1, 8'h77, 16'h7777);
    exp_cmd(1'b1, 8'h77, 16'h7777);
    exp_resp(4'b0010, 2'd1, 16'hC0DE, 1'b0);
    mem_ready = 1'b0;
    req = 4'b0010;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_nopulse", {30'b0, mem_write_req, mem_read_req}, 0);
      check("bp_busy", 32'(busy), 1);
    end
    @(posedge clk); #1 mem_ready = 1'b1;
    @(negedge clk);
    check("bp_pulse", {30'b0, mem_write_req, mem_read_req}, 32'h2);
    wait_ack("bp", n);
    @(posedge clk); #1 req = '0;

    // Reset during S_WAIT; the late mem_ack must be ignored.
    mem_delay = 3;
    set_lane(0, 1'b0, 8'h99, 16'h0099);
    exp_cmd(1'b0, 8'h99, 16'h0099);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1; req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rm_busy", 32'(busy), 0);
      check("rm_ack", 32'(ack), 0);
    end
    check("rm_rdata", 32'(rdata), 0);
    mem_delay = 2;
    mem_rd_val = 16'h1357;
    set_lane(0, 1'b0, 8'h21, 16'h2121);
    set_lane(1, 1'b1, 8'h22, 16'h2222);
    exp_cmd(1'b0, 8'h21, 16'h2121);
    exp_resp(4'b0001, 2'd0, 16'h1357, 1'b0);
    exp_cmd(1'b1, 8'h22, 16'h2222);
    exp_resp(4'b0010, 2'd1, 16'h1357, 1'b0);
    @(posedge clk); #1 req = 4'b0011;
    wait_ack("rm0", n);
    @(posedge clk); #1 req = 4'b0010;
    wait_ack("rm1", n);
    @(posedge clk); #1 req = '0;

    // Controller never acks.
    mem_ack_en = 1'b0;
    set_lane(3, 1'b0, 8'h33, 16'h3333);
    exp_cmd(1'b0, 8'h33, 16'h3333);
`ifdef ARB_TIMEOUT_EN
    exp_resp(4'b1000, 2'd3, 16'h1357, 1'b1);
    req = 4'b1000;
    wait_cmd("to");
    wait_ack("to", n);
    check("to_latency", 32'(n), 32'(17));
    @(posedge clk); #1 req = '0;
`else
    req = 4'b1000;
    wait_cmd("hang");
    repeat (40) @(negedge clk);
    check("hang_busy", 32'(busy), 1);
    #1 req = '0;
    do_reset();
`endif
    mem_ack_en = 1'b1;

    repeat (3) @(negedge clk);
    check("cmd_q_empty", 32'(cmd_q.size()), 0);
    check("resp_q_empty", 32'(resp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SRAM controller among NUM_REQ requesters. It latches one requester's command, issues a single-cycle read or write request to the controller when the controller is ready, and waits for completion. It then returns a one-cycle acknowledge, plus read data for reads, to the winning requester. It sits between the client blocks and the SRAM controller FSM.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, SRAM address width
DATA_W, 16, SRAM data width
TIMEOUT_CYCLES, 16, S_WAIT watchdog limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NUM_REQ  per-requester request, held until ack
req_we  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
rdata  out  DATA_W  read data, valid while ack is high for a read
err  out  1  completion error flag, valid with ack
grant_id  out  $clog2(NUM_REQ)  index of the latched winner
busy  out  1  high whenever state != S_IDLE
mem_read_req  out  1  one-cycle read command to the controller
mem_write_req  out  1  one-cycle write command to the controller
mem_addr  out  ADDR_W  latched address, stable from S_ISSUE until S_RESP
mem_wdata  out  DATA_W  latched write data, same stability window
mem_ready  in  1  controller idle and able to accept a command
mem_ack  in  1  controller completion pulse
mem_rdata  in  DATA_W  controller read data, valid with mem_ack

Behaviour:
- Reset (rst=1 at a clock edge): state=S_IDLE; ptr=NUM_REQ-1, so requester 0 has first priority; grant_id, mem_addr, mem_wdata and rdata are 0; ack, err, mem_read_req and mem_write_req are 0; busy is 0. Reset mid-transaction abandons the transaction; no ack is issued for it.
- S_IDLE: if any req bit is set, select the first set bit searching ptr+1, ptr+2, ... with wrap modulo NUM_REQ. Latch the winner's id, we, addr and wdata, then go to S_ISSUE. Otherwise stay in S_IDLE.
- S_ISSUE: mem_read_req = !we_lat & mem_ready and mem_write_req = we_lat & mem_ready, combinational and one cycle. When mem_ready=1, go to S_WAIT; otherwise hold in S_ISSUE with no command pulse.
- S_WAIT: on mem_ack, capture mem_rdata into rdata (reads only; writes leave rdata unchanged) and go to S_RESP. mem_ack in any other state is ignored.
- S_RESP: ack[grant_id]=1 for exactly one cycle, err=0 on normal completion. Set ptr=grant_id, then go to S_IDLE.
- ack, err and busy are decoded from registered state only and carry no combinational path from inputs. mem_addr and mem_wdata are registers driven from the latched values.
- Latency: with req sampled in S_IDLE at edge T and mem_ready=1, the command pulse occurs in cycle T+1. ack occurs in the cycle after the mem_ack cycle.
- Requester protocol: inputs are held stable until ack. Changes after latching have no effect on the in-flight transaction. The arbiter always returns to S_IDLE for at least one cycle between transactions.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 other transactions.
- Simultaneous requests are resolved only in S_IDLE. Requests arriving while busy wait for S_IDLE.

Optional Feature:
ARB_TIMEOUT_EN: when defined, a counter clears on entry to S_WAIT and increments each cycle while in S_WAIT. When it reaches TIMEOUT_CYCLES-1 without mem_ack, the arbiter goes to S_RESP with err=1, leaves rdata unchanged, and still advances ptr. When undefined, the counter is absent, err is tied to 0, and S_WAIT waits indefinitely for mem_ack.

Test Plan:
- Write: req[0]=1, we=1, addr=0x12, wdata=0xBEEF; memory model acks 2 cycles after the command -> exactly one mem_write_req pulse with mem_addr=0x12 and mem_wdata=0xBEEF; ack=4'b0001 for one cycle; err=0.
- Read: req[2]=1, we=0, addr=0x34; mem_rdata=0x5A5A with mem_ack -> one mem_read_req pulse; ack=4'b0100 with rdata=0x5A5A in the same cycle.
- Round-robin: req=4'b1111 held continuously -> grant_id sequence 0,1,2,3,0,1.
- Backpressure: mem_ready=0 for 5 cycles while in S_ISSUE -> no command pulse during those cycles; exactly one pulse in the first cycle mem_ready=1; busy stays 1 throughout.
- Reset mid-op: assert rst during S_WAIT -> next cycle busy=0 and no ack. Late mem_ack is ignored. Then req=4'b0011 -> grant_id=0 first.
- Timeout (ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16): mem_ack never arrives -> ack with err=1 exactly 16 cycles after entering S_WAIT; with the macro undefined, busy remains 1 indefinitely.
